// File: rtl/fp_encoder_seq.sv
// fp_encoder_seq: sequential linear-to-floating-point encoder.
// A two's-complement sample is captured, its magnitude is normalised one
// shift per cycle, then rounded (optional) into sign/exponent/mantissa.
// Encoded value = out_mant * 2^out_exp. Valid/ready handshake on both sides.
//
// state | meaning
// IDLE  | waiting for a sample, in_ready = 1
// NORM  | shifting magnitude left until MSB set or exponent reaches 0
// ROUND | rounding / renormalising, result registered to outputs
// DONE  | holding result until out_ready
module fp_encoder_seq #(
  parameter int DATA_W   = 12,
  parameter int MANT_W   = 4,
  parameter int EXP_W    = 3,
  parameter int ROUND_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int M      = DATA_W - 1;
  localparam int SH_MAX = M - MANT_W;

  // The exponent must be able to hold the full shift range, and at least one
  // magnitude bit must be left below the mantissa for the round bit.
  if ((SH_MAX > (2 ** EXP_W) - 1) || (MANT_W >= M)) begin : g_param_check
    $error("fp_encoder_seq: need M-MANT_W <= 2^EXP_W-1 and MANT_W < M");
  end

  localparam logic [EXP_W-1:0]  EXP_INIT  = EXP_W'(SH_MAX);
  localparam logic [EXP_W-1:0]  EXP_MAX   = '1;
  localparam logic [MANT_W-1:0] MANT_MAX  = '1;
  localparam logic [MANT_W-1:0] MANT_HALF = MANT_W'(1) << (MANT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [M-1:0]     mag;
  logic [EXP_W-1:0] exp_r;
  logic             sign_r;
  logic             clip_r;

  logic             in_neg;
  logic             in_is_min;
  logic [M-1:0]     neg_mag;
  logic [M-1:0]     cap_mag;

  logic [MANT_W-1:0] m_trunc;
  logic              r_bit;
  logic [MANT_W:0]   m_inc;
  logic [MANT_W-1:0] rnd_mant;
  logic [EXP_W-1:0]  rnd_exp;
  logic              rnd_sat;

  // Magnitude of the incoming sample; the most negative code cannot be
  // represented in M bits, so it is clipped to full scale.
  always_comb begin
    in_neg    = in_data[DATA_W-1];
    in_is_min = in_neg && (in_data[M-1:0] == '0);
    neg_mag   = (~in_data[M-1:0]) + M'(1);
    cap_mag   = in_data[M-1:0];
    if (in_is_min) begin
      cap_mag = '1;
    end else if (in_neg) begin
      cap_mag = neg_mag;
    end
  end

  // Rounding on the first discarded bit, with renormalisation or saturation
  // when the mantissa increment overflows.
  always_comb begin
    m_trunc  = mag[M-1 -: MANT_W];
    r_bit    = (exp_r != '0) && mag[SH_MAX-1];
    m_inc    = {1'b0, m_trunc} + {{MANT_W{1'b0}}, 1'b1};
    rnd_mant = m_trunc;
    rnd_exp  = exp_r;
    rnd_sat  = clip_r;
    if ((ROUND_EN != 0) && r_bit) begin
      if (!m_inc[MANT_W]) begin
        rnd_mant = m_inc[MANT_W-1:0];
      end else if (exp_r != EXP_MAX) begin
        rnd_mant = MANT_HALF;
        rnd_exp  = exp_r + EXP_W'(1);
      end else begin
        rnd_mant = MANT_MAX;
        rnd_sat  = 1'b1;
      end
    end
  end

  // Control FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mag       <= '0;
      exp_r     <= '0;
      sign_r    <= 1'b0;
      clip_r    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_mant  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r   <= in_neg;
            mag      <= cap_mag;
            clip_r   <= in_is_min;
            exp_r    <= EXP_INIT;
            in_ready <= 1'b0;
            state    <= NORM;
          end
        end
        NORM: begin
          if (mag[M-1] || (exp_r == '0)) begin
            state <= ROUND;
          end else begin
            mag   <= {mag[M-2:0], 1'b0};
            exp_r <= exp_r - EXP_W'(1);
          end
        end
        ROUND: begin
          out_sign  <= sign_r;
          out_exp   <= rnd_exp;
          out_mant  <= rnd_mant;
          out_sat   <= rnd_sat;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_encoder_seq.sv
// Directed bench for fp_encoder_seq: a rounding and a truncating instance
// share stimulus; table vectors plus backpressure and mid-NORM reset.
module tb_fp_encoder_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;

  logic       a_in_ready, a_sign, a_sat, a_valid;
  logic [2:0] a_exp;
  logic [3:0] a_mant;
  logic       b_in_ready, b_sign, b_sat, b_valid;
  logic [2:0] b_exp;
  logic [3:0] b_mant;

  fp_encoder_seq #(.DATA_W(12), .MANT_W(4), .EXP_W(3), .ROUND_EN(1)) u_rnd (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_in_ready), .out_sign(a_sign), .out_exp(a_exp),
    .out_mant(a_mant), .out_sat(a_sat), .out_valid(a_valid),
    .out_ready(out_ready)
  );

  fp_encoder_seq #(.DATA_W(12), .MANT_W(4), .EXP_W(3), .ROUND_EN(0)) u_trn (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_in_ready), .out_sign(b_sign), .out_exp(b_exp),
    .out_mant(b_mant), .out_sat(b_sat), .out_valid(b_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Counts edges after the accepting edge until out_valid; 0 on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (a_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [11:0] din;
    int lat;
    int sign;
    int exp1, mant1, sat1;
    int exp0, mant0, sat0;
  } vec_t;

  vec_t vecs[9];

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"},  a_in_ready, 1);
    chk({tag, "_out_valid"}, a_valid, 0);
    chk({tag, "_fields"},    {a_sign, a_exp, a_mant, a_sat}, 0);
    chk({tag, "_trn_valid"}, b_valid, 0);
    chk({tag, "_trn_fields"}, {b_sign, b_exp, b_mant, b_sat}, 0);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int lat;
    @(negedge clk);
    in_data  = v.din;
    in_valid = 1'b1;
    chk($sformatf("v%0d_in_ready_idle", i), a_in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk($sformatf("v%0d_in_ready_busy", i), a_in_ready, 0);
    wait_valid(lat);
    chk($sformatf("v%0d_latency", i), lat, v.lat);
    chk($sformatf("v%0d_sign", i), a_sign, v.sign);
    chk($sformatf("v%0d_exp", i),  a_exp,  v.exp1);
    chk($sformatf("v%0d_mant", i), a_mant, v.mant1);
    chk($sformatf("v%0d_sat", i),  a_sat,  v.sat1);
    chk($sformatf("v%0d_trn_valid", i), b_valid, 1);
    chk($sformatf("v%0d_trn_sign", i), b_sign, v.sign);
    chk($sformatf("v%0d_trn_exp", i),  b_exp,  v.exp0);
    chk($sformatf("v%0d_trn_mant", i), b_mant, v.mant0);
    chk($sformatf("v%0d_trn_sat", i),  b_sat,  v.sat0);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_valid_drop", i), a_valid, 0);
    chk($sformatf("v%0d_mant_hold", i), a_mant, v.mant1);
  endtask

  initial begin
    int lat;
    logic [7:0] snap;

    //         din        lat sg  e1 m1 s1  e0 m0 s0
    vecs[0] = '{12'd422,    4, 0,  5, 13, 0, 5, 13, 0};
    vecs[1] = '{12'd125,    6, 0,  4,  8, 0, 3, 15, 0};
    vecs[2] = '{12'd2047,   2, 0,  7, 15, 1, 7, 15, 0};
    vecs[3] = '{12'h800,    2, 1,  7, 15, 1, 7, 15, 1};
    vecs[4] = '{12'd0,      9, 0,  0,  0, 0, 0,  0, 0};
    vecs[5] = '{12'hFFB,    9, 1,  0,  5, 0, 0,  5, 0};
    vecs[6] = '{12'd17,     8, 0,  1,  9, 0, 1,  8, 0};
    vecs[7] = '{12'hE5A,    4, 1,  5, 13, 0, 5, 13, 0};
    vecs[8] = '{12'd1,      9, 0,  0,  1, 0, 0,  1, 0};

    #1 rst = 1'b1;
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_vec(i, vecs[i]);
    end

    // Backpressure with in_valid held high throughout.
    @(negedge clk);
    out_ready = 1'b0;
    in_data   = 12'd422;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_data = 12'd125;
    wait_valid(lat);
    chk("bp_latency", lat, 4);
    snap = {a_sign, a_exp, a_mant};
    chk("bp_first_fields", snap, {1'b0, 3'd5, 4'd13});
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold_fields_%0d", k), {a_sign, a_exp, a_mant}, {1'b0, 3'd5, 4'd13});
      chk($sformatf("bp_hold_valid_%0d", k), a_valid, 1);
      chk($sformatf("bp_in_ready_%0d", k), a_in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_handshake_valid", a_valid, 0);
    chk("bp_handshake_in_ready", a_in_ready, 1);
    @(posedge clk);
    #1;
    chk("bp_next_accepted", a_in_ready, 0);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_next_latency", lat, 6);
    chk("bp_next_exp", a_exp, 4);
    chk("bp_next_mant", a_mant, 8);
    chk("bp_next_sat", a_sat, 0);
    @(posedge clk);
    #1;

    // Asynchronous reset while normalising.
    @(negedge clk);
    in_data  = 12'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_state("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    run_vec(9, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_encoder_seq.md
Name: fp_encoder_seq

Overview:
- Sequential, parametrised linear-to-floating-point encoder.
- Takes a two's-complement sample and produces sign, exponent and mantissa, with optional round-to-nearest, renormalisation on mantissa overflow, and saturation.
- Normalisation is iterative, one shift per cycle.
- Sits between the sample source and the display/encode path, with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 12, input sample width (two's complement). Magnitude width M = DATA_W-1.
- MANT_W, 4, mantissa width.
- EXP_W, 3, exponent width. Elaboration must fail unless M-MANT_W <= 2^EXP_W-1 and MANT_W < M.
- ROUND_EN, 1, 1 = round on the first discarded bit; 0 = truncate.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  two's-complement sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample.
- out_sign  out  1  sign of the accepted sample.
- out_exp  out  EXP_W  exponent.
- out_mant  out  MANT_W  mantissa. Encoded value = out_mant * 2^out_exp.
- out_sat  out  1  magnitude was clipped, or rounding saturated.
- out_valid  out  1  output fields are valid.
- out_ready  in  1  consumer accepts the output.

Behaviour:
- Reset (async, any state): state = IDLE, in_ready = 1, out_valid = 0, out_sign/out_exp/out_mant/out_sat = 0. Any in-flight sample is discarded.
- States:
  - IDLE -> NORM, NORM -> NORM/ROUND, ROUND -> DONE, DONE -> IDLE.
  - in_ready = 1 only in IDLE.
- IDLE:
  - On in_valid & in_ready, capture sign = in_data[DATA_W-1].
  - mag = |in_data| as M bits.
  - The value -2^(DATA_W-1) sets mag = 2^M-1 and clip = 1; otherwise clip = 0.
  - Set exp = M-MANT_W. Go to NORM.
- NORM, per cycle:
  - If mag[M-1] = 1 or exp = 0, go to ROUND and leave mag unchanged.
  - Otherwise mag <<= 1 and exp -= 1.
  - Shift count s = min(leading zeros of mag, M-MANT_W).
- ROUND:
  - m = mag[M-1 : M-MANT_W]. r = mag[M-MANT_W-1] if exp > 0, else 0.
  - ROUND_EN = 0 or r = 0: result (m, exp).
  - m+r <= 2^MANT_W-1: result (m+1, exp).
  - Overflow and exp < 2^EXP_W-1: result (2^(MANT_W-1), exp+1).
  - Overflow and exp at max: result (2^MANT_W-1, exp), with out_sat = 1.
  - out_sat also = 1 if clip = 1.
  - Outputs are registered; out_valid = 1. Go to DONE.
- Latency: out_valid rises s+2 cycles after the accepting edge. Range is 2 to M-MANT_W+2; 2 to 9 with defaults.
- DONE:
  - Outputs stay stable while out_valid & !out_ready.
  - On out_ready, out_valid = 0 next cycle and state = IDLE.
  - A new sample is accepted no earlier than the cycle after the handshake.
- in_data is ignored outside IDLE. in_valid may be held high: the next sample is accepted on the first IDLE cycle.
- Zero input: exp reaches 0, result mant = 0, exp = 0, sign = 0, out_sat = 0.
- Output fields hold their last value after out_valid falls. Reset clears them.

Test Plan:
- Defaults, in_data = 422, out_ready = 1 -> sign 0, exp 5, mant 13, sat 0; out_valid exactly 4 cycles after accept.
- in_data = 125 (rounding renormalisation) -> exp 4, mant 8, sat 0.
- in_data = 2047 -> exp 7, mant 15, sat 1 (rounding saturated). in_data = -2048 -> sign 1, exp 7, mant 15, sat 1. Repeat 2047 with ROUND_EN = 0 -> exp 7, mant 15, sat 0.
- in_data = 0 -> exp 0, mant 0, sign 0, out_valid 9 cycles after accept. in_data = -5 -> sign 1, exp 0, mant 5.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid with in_valid held high -> outputs constant, in_ready = 0; after out_ready pulses, the next sample is accepted the following cycle.
- Assert rst mid-NORM (e.g. 2 cycles after accepting 5) -> out_valid = 0, in_ready = 1, outputs 0 immediately without a clock edge; the next sample encodes correctly.
